// File: rtl/sdp_fifo_ctrl.sv
// First-word-fall-through FIFO controller for an external simple-dual-port BRAM.
// A 2-entry output buffer hides the 1-cycle registered read so one word/cycle is sustained.
module sdp_fifo_ctrl #(
    parameter int ABITS = 4,
    parameter int DBITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DBITS-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DBITS-1:0] m_data,
    output logic             mem_we,
    output logic [ABITS-1:0] mem_wa,
    output logic [DBITS-1:0] mem_wd,
    output logic [ABITS-1:0] mem_ra,
    input  logic [DBITS-1:0] mem_rd,
    output logic [ABITS+1:0] count
);

    localparam logic [ABITS:0] DEPTH = {1'b1, {ABITS{1'b0}}};

    logic             r_run;
    logic [ABITS-1:0] r_wr_ptr;
    logic [ABITS-1:0] r_rd_ptr;
    logic [ABITS:0]   r_ram_cnt;
    logic             r_inflight;
    logic [1:0]       r_ob_cnt;
    logic [DBITS-1:0] r_ob0;
    logic [DBITS-1:0] r_ob1;

    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    logic [1:0]       w_occ;
    logic [1:0]       w_base;
    logic [1:0]       w_ob_cnt_nxt;
    logic [DBITS-1:0] w_ob0_nxt;
    logic [DBITS-1:0] w_ob1_nxt;

    assign s_ready = r_run && (r_ram_cnt != DEPTH);
    assign w_push  = s_valid && s_ready;
    assign m_valid = (r_ob_cnt != 2'd0);
    assign w_pop   = m_valid && m_ready;
    assign m_data  = r_ob0;

    assign mem_we  = w_push;
    assign mem_wa  = r_wr_ptr;
    assign mem_wd  = s_data;
    assign mem_ra  = r_rd_ptr;

    // Buffer slots claimed after this cycle's pop must leave room for the word being issued.
    assign w_occ   = r_ob_cnt + {1'b0, r_inflight};
    assign w_issue = (r_ram_cnt != '0) && (w_occ <= ({1'b0, w_pop} + 2'd1));

    assign w_ob_cnt_nxt = r_ob_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_base       = r_ob_cnt - {1'b0, w_pop};

    assign count = {1'b0, r_ram_cnt} + (ABITS+2)'(r_inflight) + (ABITS+2)'(r_ob_cnt);

    always_comb begin
        w_ob0_nxt = r_ob0;
        w_ob1_nxt = r_ob1;
        if (w_pop) begin
            w_ob0_nxt = r_ob1;
        end
        // Returning read data lands in the first slot that is free after the shift.
        if (r_inflight) begin
            if (w_base == 2'd0) begin
                w_ob0_nxt = mem_rd;
            end else begin
                w_ob1_nxt = mem_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_ob_cnt   <= '0;
            r_ob0      <= '0;
            r_ob1      <= '0;
        end else begin
            r_run      <= 1'b1;
            r_inflight <= w_issue;
            r_ob_cnt   <= w_ob_cnt_nxt;
            r_ob0      <= w_ob0_nxt;
            r_ob1      <= w_ob1_nxt;
            r_ram_cnt  <= r_ram_cnt + (ABITS+1)'(w_push) - (ABITS+1)'(w_issue);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ABITS'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + ABITS'(1);
            end
        end
    end

endmodule

// File: doc/sdp_fifo_ctrl.md
# sdp_fifo_ctrl

Synchronous first-word-fall-through FIFO controller that drives an external simple-dual-port BRAM through its `we`/`wa`/`wd`/`ra`/`rd` ports. The BRAM is the block checked by the SDP gold/gate equivalence flow. This controller is the stage directly upstream of it: it produces every write and read address and consumes the BRAM read data. Its valid/ready interfaces let QLF BRAM inference be exercised with realistic streaming traffic. It hides the BRAM's 1-cycle registered read latency behind a 2-entry output buffer so it can sustain one word per cycle.

## Interface
- `ABITS`, default 4: BRAM address width; the RAM holds 2^ABITS words.
- `DBITS`, default 8: data width.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: upstream word valid.
- `s_ready` out 1: controller can accept a word.
- `s_data` in DBITS: upstream word.
- `m_valid` out 1: head word available.
- `m_ready` in 1: downstream takes the head word.
- `m_data` out DBITS: head word.
- `mem_we` out 1: BRAM write enable.
- `mem_wa` out ABITS: BRAM write address.
- `mem_wd` out DBITS: BRAM write data.
- `mem_ra` out ABITS: BRAM read address. The BRAM registers `rd` from `ra` every cycle.
- `mem_rd` in DBITS: BRAM read data, valid 1 cycle after `mem_ra`.
- `count` out ABITS+2: total words held (RAM + in-flight + output buffer).

## Operation
- **State**
  - `wr_ptr`, `rd_ptr`: ABITS bits each, wrap modulo 2^ABITS.
  - `ram_cnt`: 0..2^ABITS.
  - `inflight`: 0/1.
  - Output buffer: 2 slots, `ob_cnt` 0..2. The head slot drives `m_data`/`m_valid`.
- **Push**
  - `push = s_valid && s_ready`.
  - `s_ready = (ram_cnt != 2^ABITS)`, combinational from registered state.
  - `mem_we = push`, `mem_wa = wr_ptr`, `mem_wd = s_data` (all combinational).
  - `wr_ptr` increments on push.
- **Pop**
  - `pop = m_valid && m_ready`.
  - `m_valid = (ob_cnt != 0)`.
  - On pop, the second slot (if any) shifts to head.
- **Read issue**
  - `issue = (ram_cnt != 0) && (ob_cnt + inflight - pop <= 1)`.
  - `mem_ra = rd_ptr` always. `rd_ptr` increments on issue.
  - Next `inflight = issue`.
  - When `inflight` is set, `mem_rd` is written into the first free slot after this cycle's pop shift.
- **Counter updates**
  - `ram_cnt += push - issue`.
  - `ob_cnt += inflight - pop`.
  - `count = ram_cnt + inflight + ob_cnt`, maximum 2^ABITS+2.
- **Read/write hazard**
  - A read targets only addresses written in an earlier cycle, because `ram_cnt` is registered.
  - `mem_wa != mem_ra` whenever `mem_we && issue`. This avoids the undefined SDP read-during-write on the same address.
- **Boundary cases**
  - Full (`ram_cnt == 2^ABITS`): `s_ready` is 0. A push and an issue in the same cycle leave `ram_cnt` unchanged.
  - Empty: `m_valid` is 0 and no issue occurs.
  - A push into an empty FIFO is never bypassed to the output. It always travels through the BRAM.
  - Pointers wrap silently from 2^ABITS-1 to 0.
- **Reset**
  - Asserting `rst_n` low at any time immediately clears all pointers, counters, `inflight` and `ob_cnt`, and sets buffer data to 0.
  - Outputs under reset: `s_ready` 0, `m_valid` 0, `m_data` 0, `mem_we` 0, `mem_wa` 0, `mem_ra` 0, `count` 0.
  - `s_ready` rises on the first edge after deassertion.
  - Words in flight at reset are discarded.

## Timing
- Latency from push to `m_valid` on an empty FIFO: 2 cycles.
  - Push at edge t.
  - Issue in cycle t+1.
  - `m_valid` = 1 after edge t+2.
- Throughput: 1 word/cycle sustained with `s_valid` = `m_ready` = 1.
- `m_data`/`m_valid` stay stable while `m_valid && !m_ready`.
- Combinational paths:
  - `s_ready`, `m_valid`, `count` depend only on registered state.
  - `mem_we` depends on `s_valid`.
  - `issue` depends on `m_ready`.
  - There is no path from `m_ready` to `s_ready`.

## Test plan
- **Reset values:** hold `rst_n` = 0 with random inputs -> `s_ready` = 0, `m_valid` = 0, `count` = 0, `mem_we` = 0. Release -> `s_ready` = 1 next edge.
- **Single word:** push `0xA5` at cycle 0 with `m_ready` = 1 -> `mem_we` = 1, `mem_wa` = 0 at cycle 0; `mem_ra` = 0 with issue at cycle 1; `m_valid` = 1, `m_data` = `0xA5` at cycle 2; `count` returns to 0 after the pop.
- **Fill with backpressure:** `ABITS` = 4, `m_ready` = 0, push 0..19 -> exactly 18 accepted; `s_ready` = 0; `count` = 18; `m_data` = 0. Then `m_ready` = 1 -> pops 0..17 in order.
- **Streaming with wrap:** push 40 incrementing words, `m_ready` = 1 -> `m_valid` continuous from cycle 2; outputs 0..39 on consecutive cycles; `wr_ptr`/`rd_ptr` wrap twice; no stall.
- **Random traffic:** random `s_valid`/`m_ready` over 10k cycles against a reference queue. Required: order and data preserved; `count` exact; `mem_wa != mem_ra` whenever `mem_we` and issue; stable `m_data` under stall.
- **Reset mid-operation:** assert `rst_n` low with `count` = 10 and a read in flight -> immediate clear. After release, push `0x3C` -> it is the first word out, 2 cycles later.
